// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I/M/A decode stage.
package decode_stage_pkg;

  localparam int unsigned ImmMaxW = 64;
  localparam int unsigned PcMaxW  = 64;

  typedef enum logic [6:0] {
    OpLoad    = 7'b0000011,
    OpMiscMem = 7'b0001111,
    OpImm     = 7'b0010011,
    OpAuipc   = 7'b0010111,
    OpStore   = 7'b0100011,
    OpAmo     = 7'b0101111,
    OpReg     = 7'b0110011,
    OpLui     = 7'b0110111,
    OpBranch  = 7'b1100011,
    OpJalr    = 7'b1100111,
    OpJal     = 7'b1101111,
    OpSystem  = 7'b1110011
  } e_opcode;

  typedef enum logic [2:0] {
    F3AddSub = 3'b000,
    F3Sll    = 3'b001,
    F3Slt    = 3'b010,
    F3Sltu   = 3'b011,
    F3Xor    = 3'b100,
    F3SrlSra = 3'b101,
    F3Or     = 3'b110,
    F3And    = 3'b111
  } e_funct3_alu;

  typedef enum logic [4:0] {
    AmoAdd  = 5'b00000,
    AmoSwap = 5'b00001,
    AmoLr   = 5'b00010,
    AmoSc   = 5'b00011,
    AmoXor  = 5'b00100,
    AmoOr   = 5'b01000,
    AmoAnd  = 5'b01100,
    AmoMin  = 5'b10000,
    AmoMax  = 5'b10100,
    AmoMinu = 5'b11000,
    AmoMaxu = 5'b11100
  } e_funct5_amo;

  typedef enum logic [2:0] {
    ITypeR = 3'd0,
    ITypeI = 3'd1,
    ITypeS = 3'd2,
    ITypeB = 3'd3,
    ITypeU = 3'd4,
    ITypeJ = 3'd5
  } e_instr_type;

  localparam logic [6:0]  F7_BASE   = 7'b0000000;
  localparam logic [6:0]  F7_ALT    = 7'b0100000;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Stored at maximum width; the stage slices pc/imm down to PC_W/XLEN.
  typedef struct packed {
    logic [PcMaxW-1:0]  pc;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [ImmMaxW-1:0] imm;
    e_instr_type        itype;
    logic               is_mul;
    logic               is_atomic;
    logic               is_nop;
    logic               illegal;
  } t_decoded;

endpackage

// File: rtl/decode_stage_decoder.sv
// Combinational RV32I/M/A instruction cracker: fields, class, immediate, legality.
// RV32A_DECODE_EN enables decoding of the AMO opcode; otherwise it is illegal.
module instr_decoder
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0] instr_i,
  output t_decoded    dec_o
);

  if (!(XLEN == 32 || XLEN == 64)) begin : gen_xlen_check
    $error("instr_decoder: XLEN must be 32 or 64");
  end

  e_opcode     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  funct5;
  logic [4:0]  rs2;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = e_opcode'(instr_i[6:0]);
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign funct5 = instr_i[31:27];
  assign rs2    = instr_i[24:20];

  assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
  assign imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                  1'b0};

  // Field extraction, class/immediate selection and legality checks.
  always_comb begin
    dec_o         = '0;
    dec_o.opcode  = instr_i[6:0];
    dec_o.funct3  = funct3;
    dec_o.funct7  = funct7;
    dec_o.rd      = instr_i[11:7];
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = rs2;
    dec_o.itype   = ITypeR;
    dec_o.is_nop  = (instr_i == NOP_INSTR);
    dec_o.is_mul  = (opcode == OpReg) && (funct7 == F7_MULDIV);
    dec_o.illegal = (instr_i[1:0] != 2'b11);
    case (opcode)
      OpLoad: begin
        dec_o.itype = ITypeI;
        dec_o.imm   = imm_i;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec_o.illegal = 1'b1;
      end
      OpMiscMem, OpJalr, OpSystem: begin
        dec_o.itype = ITypeI;
        dec_o.imm   = imm_i;
      end
      OpImm: begin
        dec_o.itype = ITypeI;
        dec_o.imm   = imm_i;
        if (funct3 == F3Sll && funct7 != F7_BASE) dec_o.illegal = 1'b1;
        if (funct3 == F3SrlSra && funct7 != F7_BASE && funct7 != F7_ALT) dec_o.illegal = 1'b1;
      end
      OpAuipc, OpLui: begin
        dec_o.itype = ITypeU;
        dec_o.imm   = imm_u;
      end
      OpStore: begin
        dec_o.itype = ITypeS;
        dec_o.imm   = imm_s;
        if (funct3 >= 3'b011) dec_o.illegal = 1'b1;
      end
      OpReg: begin
        dec_o.itype = ITypeR;
        if (funct7 != F7_BASE && funct7 != F7_ALT && funct7 != F7_MULDIV) dec_o.illegal = 1'b1;
        if (funct7 == F7_ALT && funct3 != F3AddSub && funct3 != F3SrlSra) dec_o.illegal = 1'b1;
      end
      OpBranch: begin
        dec_o.itype = ITypeB;
        dec_o.imm   = imm_b;
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_o.illegal = 1'b1;
      end
      OpJal: begin
        dec_o.itype = ITypeJ;
        dec_o.imm   = imm_j;
      end
`ifdef RV32A_DECODE_EN
      OpAmo: begin
        dec_o.itype     = ITypeR;
        dec_o.is_atomic = 1'b1;
        if (funct3 != 3'b010) dec_o.illegal = 1'b1;
        case (funct5)
          AmoAdd, AmoSwap, AmoLr, AmoSc, AmoXor, AmoOr, AmoAnd,
          AmoMin, AmoMax, AmoMinu, AmoMaxu: ;
          default: dec_o.illegal = 1'b1;
        endcase
        if (funct5 == AmoLr && rs2 != 5'd0) dec_o.illegal = 1'b1;
      end
`endif
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: two-entry (head + skid) buffer around instr_decoder.
// RV32A_DECODE_EN enables atomic decoding; undefined ties out_is_atomic_o to 0.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [PC_W-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] out_pc_o,
  output logic [6:0]      out_opcode_o,
  output logic [2:0]      out_funct3_o,
  output logic [6:0]      out_funct7_o,
  output logic [4:0]      out_funct5_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_itype_o,
  output logic            out_is_mul_o,
  output logic            out_is_atomic_o,
  output logic            out_is_nop_o,
  output logic            out_illegal_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} e_buf_state;

  e_buf_state state_q, state_d;
  t_decoded   head_q, head_d, skid_q, skid_d;
  t_decoded   dec, dec_in;
  logic       accept, pop;

  instr_decoder #(
    .XLEN(XLEN)
  ) u_decoder (
    .instr_i(in_instr_i),
    .dec_o  (dec)
  );

  assign in_ready_o  = (state_q != StFull) && !rst_i && !flush_i;
  assign out_valid_o = (state_q != StEmpty);
  assign accept      = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Attach the PC to the decoded word before it is buffered.
  always_comb begin
    dec_in    = dec;
    dec_in.pc = PcMaxW'(in_pc_i);
  end

  // Buffer occupancy transitions; flush empties regardless of accept/pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = dec_in;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_d = dec_in;
          end else if (accept) begin
            skid_d  = dec_in;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State and entry registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign out_pc_o     = head_q.pc[PC_W-1:0];
  assign out_opcode_o = head_q.opcode;
  assign out_funct3_o = head_q.funct3;
  assign out_funct7_o = head_q.funct7;
  assign out_funct5_o = head_q.funct7[6:2];
  assign out_rd_o     = head_q.rd;
  assign out_rs1_o    = head_q.rs1;
  assign out_rs2_o    = head_q.rs2;
  assign out_imm_o    = head_q.imm[XLEN-1:0];
  assign out_itype_o  = head_q.itype;
  assign out_is_mul_o = head_q.is_mul;
  assign out_is_nop_o = head_q.is_nop;
  assign out_illegal_o = head_q.illegal;

`ifdef RV32A_DECODE_EN
  assign out_is_atomic_o = head_q.is_atomic;
`else
  assign out_is_atomic_o = 1'b0;
`endif

  // Upper pc/imm bits beyond PC_W/XLEN are intentionally dropped.
  logic unused_head;
  assign unused_head = ^{head_q.pc, head_q.imm, head_q.is_atomic};

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=64, PC_W=32) with an output scoreboard.
module tb_decode_stage;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_itype;
  logic [4:0]  out_funct5, out_rd, out_rs1, out_rs2;
  logic [63:0] out_imm;
  logic        out_is_mul, out_is_atomic, out_is_nop, out_illegal;

  decode_stage #(
    .XLEN(64),
    .PC_W(32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_instr_i     (in_instr),
    .in_pc_i        (in_pc),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_opcode_o   (out_opcode),
    .out_funct3_o   (out_funct3),
    .out_funct7_o   (out_funct7),
    .out_funct5_o   (out_funct5),
    .out_rd_o       (out_rd),
    .out_rs1_o      (out_rs1),
    .out_rs2_o      (out_rs2),
    .out_imm_o      (out_imm),
    .out_itype_o    (out_itype),
    .out_is_mul_o   (out_is_mul),
    .out_is_atomic_o(out_is_atomic),
    .out_is_nop_o   (out_is_nop),
    .out_illegal_o  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {is_mul, is_atomic, is_nop, illegal}; full=0 checks only pc and flags.
  typedef struct {
    logic [31:0] instr;
    logic        full;
    logic [2:0]  itype;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [3:0]  flags;
    logic [31:0] pc;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cur_idx = 0;
  exp_t sb[$];

  function automatic exp_t mk(input logic [31:0] instr, input logic full, input logic [2:0] itype,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [63:0] imm,
                              input logic [3:0] flags);
    exp_t e;
    e.instr = instr; e.full = full; e.itype = itype; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.f3 = f3; e.imm = imm; e.flags = flags; e.pc = '0;
    return e;
  endfunction

  // Hand-decoded reference table (itype: R0 I1 S2 B3 U4 J5).
  function automatic exp_t tbl(input int i);
    case (i)
      0:  return mk(32'h00500093, 1, 3'd1, 5'd1, 5'd0, 5'd5, 3'd0, 64'd5, 4'b0000);
      1:  return mk(32'hFE000EE3, 1, 3'd3, 5'd29, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC,
                    4'b0000);
      2:  return mk(32'h02B50533, 1, 3'd0, 5'd10, 5'd10, 5'd11, 3'd0, 64'd0, 4'b1000);
      3:  return mk(32'h00000013, 1, 3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 4'b0010);
      4:  return mk(32'hFFFFFFFF, 0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 4'b0001);
      5:  return mk(32'h00003003, 1, 3'd1, 5'd0, 5'd0, 5'd0, 3'd3, 64'd0, 4'b0001);
`ifdef RV32A_DECODE_EN
      6:  return mk(32'h100522AF, 1, 3'd0, 5'd5, 5'd10, 5'd0, 3'd2, 64'd0, 4'b0100);
`else
      6:  return mk(32'h100522AF, 0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 4'b0001);
`endif
      7:  return mk(32'h00112623, 1, 3'd2, 5'd12, 5'd2, 5'd1, 3'd2, 64'd12, 4'b0000);
      8:  return mk(32'h123452B7, 1, 3'd4, 5'd5, 5'd8, 5'd3, 3'd5, 64'h12345000, 4'b0000);
      9:  return mk(32'hFFDFF0EF, 1, 3'd5, 5'd1, 5'd31, 5'd29, 3'd7, 64'hFFFF_FFFF_FFFF_FFFC,
                    4'b0000);
      10: return mk(32'h40001013, 1, 3'd1, 5'd0, 5'd0, 5'd0, 3'd1, 64'h400, 4'b0001);
      11: return mk(32'h40B50533, 1, 3'd0, 5'd10, 5'd10, 5'd11, 3'd0, 64'd0, 4'b0000);
      default: return mk(32'h40B53533, 1, 3'd0, 5'd10, 5'd10, 5'd11, 3'd3, 64'd0, 4'b0001);
    endcase
  endfunction

  task automatic drive(input int idx, input logic v, input logic [31:0] pc);
    exp_t e;
    e        = tbl(idx);
    cur_idx  = idx;
    in_valid = v;
    in_instr = e.instr;
    in_pc    = pc;
  endtask

  // Scoreboard: inputs change on negedge; transfers are judged 1 time unit later.
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected got pc=%h instr_op=%b required no output", out_pc,
                   out_opcode);
        end else begin
          e = sb.pop_front();
          if (out_pc !== e.pc) begin
            n_err++;
            $display("FAIL sb_pc got=%h required=%h", out_pc, e.pc);
          end
          n_cmp++;
          if ({out_is_mul, out_is_atomic, out_is_nop, out_illegal} !== e.flags) begin
            n_err++;
            $display("FAIL sb_flags instr=%h got=%b required=%b", e.instr,
                     {out_is_mul, out_is_atomic, out_is_nop, out_illegal}, e.flags);
          end
          if (e.full) begin
            n_cmp++;
            if (out_itype !== e.itype) begin
              n_err++;
              $display("FAIL sb_itype instr=%h got=%0d required=%0d", e.instr, out_itype,
                       e.itype);
            end
            n_cmp++;
            if ({out_rd, out_rs1, out_rs2, out_funct3} !== {e.rd, e.rs1, e.rs2, e.f3}) begin
              n_err++;
              $display("FAIL sb_fields instr=%h got rd=%0d rs1=%0d rs2=%0d f3=%0d required %0d %0d %0d %0d",
                       e.instr, out_rd, out_rs1, out_rs2, out_funct3, e.rd, e.rs1, e.rs2, e.f3);
            end
            n_cmp++;
            if (out_imm !== e.imm) begin
              n_err++;
              $display("FAIL sb_imm instr=%h got=%h required=%h", e.instr, out_imm, e.imm);
            end
            n_cmp++;
            if (out_opcode !== e.instr[6:0]) begin
              n_err++;
              $display("FAIL sb_opcode instr=%h got=%b required=%b", e.instr, out_opcode,
                       e.instr[6:0]);
            end
          end
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        n        = tbl(cur_idx);
        n.pc     = in_pc;
        sb.push_back(n);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_handshake got in_ready/out_valid=%b required=00", {in_ready, out_valid});
    end
    n_cmp++;
    if ({out_pc, out_imm, out_rd, out_rs1, out_rs2, out_itype, out_opcode} !== '0) begin
      n_err++;
      $display("FAIL reset_fields got pc=%h imm=%h op=%b required all zero", out_pc, out_imm,
               out_opcode);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    out_ready = 1'b1;
    drive(0, 1'b1, 32'h0000_0100);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL single_latency got out_valid=%b required=1", out_valid);
    end
  endtask

  task automatic test_decode_table();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(i, 1'b1, 32'h1000 + 32'(4 * i));
      #2;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL table_throughput idx=%0d got in_ready=%b required=1", i, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) @(negedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL table_drain got pending=%0d required=0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    int seq[5] = '{2, 7, 8, 9, 11};
    int k = 0;
    int cyc = 0;
    while (k < 5 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      drive(seq[k], 1'b1, 32'h2000 + 32'(4 * k));
      #2;
      if (cyc == 1 || cyc == 2) begin
        n_cmp++;
        if (out_pc !== 32'h2000) begin
          n_err++;
          $display("FAIL bp_head_stable cyc=%0d got=%h required=00002000", cyc, out_pc);
        end
      end
      if (cyc == 2) begin
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b01) begin
          n_err++;
          $display("FAIL bp_full got in_ready/out_valid=%b required=01", {in_ready, out_valid});
        end
      end
      if (in_ready) k++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (k != 5) begin
      n_err++;
      $display("FAIL bp_accept_count got=%0d required=5", k);
    end
    for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) @(negedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain got pending=%0d required=0", sb.size());
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    drive(0, 1'b1, 32'h3000);
    @(negedge clk);
    drive(3, 1'b1, 32'h3004);
    @(negedge clk);
    drive(7, 1'b1, 32'hDEAD0);
    flush     = 1'b1;
    out_ready = 1'b1;
    #2;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready got=%b required=0", in_ready);
    end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #2;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_empty got out_valid/in_ready=%b required=01", {out_valid, in_ready});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0;
    drive(8, 1'b1, 32'h5000);
    @(negedge clk);
    drive(9, 1'b1, 32'h5004);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({out_valid, out_pc} !== 33'd0) begin
      n_err++;
      $display("FAIL midreset got out_valid=%b pc=%h required 0/00000000", out_valid, out_pc);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_atomic();
    @(negedge clk);
    out_ready = 1'b1;
    drive(6, 1'b1, 32'h4000);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    n_cmp++;
`ifdef RV32A_DECODE_EN
    if ({out_valid, out_funct5, out_is_atomic, out_illegal} !== {1'b1, 5'b00010, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL lrw_decode got v=%b f5=%b atomic=%b illegal=%b required 1 00010 1 0",
               out_valid, out_funct5, out_is_atomic, out_illegal);
    end
`else
    if ({out_valid, out_is_atomic, out_illegal} !== 3'b101) begin
      n_err++;
      $display("FAIL lrw_decode got v=%b atomic=%b illegal=%b required 1 0 1", out_valid,
               out_is_atomic, out_illegal);
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_decode_table();
    test_backpressure();
    test_flush();
    test_atomic();
    test_reset_midstream();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL final_pending got=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered RV32I/M/A instruction-decode pipeline stage with a valid/ready handshake on both sides. It sits between fetch and issue, cracks a 32-bit instruction into fields, type class, sign-extended immediate and legality flags, and buffers up to two decoded entries so back-pressure never drops or reorders instructions. A pipeline flush clears it.

## Interface
- XLEN, 32, datapath width for the immediate; legal values 32 or 64.
- PC_W, 32, width of the program counter carried alongside the instruction.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries and any input offered this cycle.
- in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both are high.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_pc  out  PC_W  PC of the head entry.
- out_opcode, out_funct3, out_funct7  out  7, 3, 7  raw fields; out_funct5 = out_funct7[6:2].
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate (0 for R-type).
- out_itype  out  3  class: R, I, S, B, U, J (package enum).
- out_is_mul, out_is_atomic, out_is_nop, out_illegal  out  1 each  decode flags.

## Operation
- Two-entry buffer, head and skid. States EMPTY, ONE, FULL; head always drives the out_* fields.
- Transitions: EMPTY + accept -> ONE. ONE + accept, no pop -> FULL. ONE + pop, no accept -> EMPTY. ONE + accept + pop -> ONE (new entry becomes head). FULL + pop -> ONE (skid moves to head). FULL never accepts.
- in_ready = 1 in EMPTY/ONE, 0 in FULL; forced to 0 while rst or flush is high.
- Decoding is combinational on in_instr and registered on accept.
- Immediates per type: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U = {instr[31:12], 12'b0}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}. Sign-extend from instr[31] to XLEN.
- out_is_nop = 1 only for instruction word 0x00000013.
- out_is_mul = 1 when opcode is 0110011 and funct7 is 0000001.
- out_illegal is set when:
  - the opcode is unknown, or the low two bits are not 11;
  - load funct3 is 011, 110 or 111; store funct3 is 011 or higher; branch funct3 is 010 or 011;
  - an R-type funct7 is outside {0000000, 0100000, 0000001}, or 0100000 is used with a funct3 other than 000 or 101;
  - SLLI funct7 is not 0, or SRLI/SRAI funct7 is outside {0000000, 0100000};
  - an atomic instruction has funct3 other than 010 or an unlisted funct5, or is an LR with rs2 != 0.
- Illegal instructions still flow through the stage with the flag set; they are not dropped.
- On flush: state -> EMPTY on the next edge. The input offered in the flush cycle is not accepted. A pop in the flush cycle is still counted downstream.

## Timing
- Latency: an accepted instruction appears on out_* at the next edge (1 cycle) if the buffer was EMPTY, or when the head pops if not.
- Throughput: 1 instruction per cycle while out_ready is held high.
- Reset values: out_valid 0, all out_* fields 0, state EMPTY. in_ready is 0 during rst and 1 in the first cycle after reset.
- out_* fields stay stable while out_valid=1 and out_ready=0.
- rst takes priority over flush, and flush over accept and pop. Reset mid-stream discards both entries.

## Configuration
- RV32A_DECODE_EN defined: opcode 0101111 decodes as R-type with out_is_atomic=1 and is subject to the atomic legality checks above.
- RV32A_DECODE_EN undefined: opcode 0101111 gives out_illegal=1 and out_is_atomic is tied to 0.

## Structure
- Shared package additions:
  - e_instr_type enum (R, I, S, B, U, J).
  - R-type funct7 constants: BASE 0000000, ALT 0100000, MULDIV 0000001.
  - NOP_INSTR = 32'h00000013.
  - A packed struct t_decoded holding every out_* field except the handshake.
- Existing opcode and funct3/funct5 enums are reused unchanged.
- One sub-module, instr_decoder: purely combinational, instr -> t_decoded, parametrised by XLEN. decode_stage adds the buffer FSM and handshake around it.

## Test plan
- 0x00500093 (addi x1,x0,5) into an EMPTY stage, out_ready=1 -> next cycle out_valid=1, itype I, rd=1, rs1=0, imm=5, no flags set.
- 0xFE000EE3 (beq x0,x0,-4) with XLEN=64 -> itype B, imm=0xFFFFFFFFFFFFFFFC; 0x02B50533 -> is_mul=1, funct3=000, rd=10, rs1=10, rs2=11.
- Stream 5 instructions with out_ready=0 for 3 cycles -> state FULL, in_ready=0, then all 5 emerge in order with no loss or duplication.
- Assert flush while FULL and in_valid=1 -> next cycle out_valid=0 and state EMPTY; the offered instruction never appears.
- 0x100522AF (lr.w x5,(x10)) -> with RV32A_DECODE_EN: is_atomic=1, funct5=00010, illegal=0; without the macro: illegal=1.
- 0x00000013 -> is_nop=1; 0xFFFFFFFF and 0x00003003 (funct3 011 load) -> illegal=1; assert rst mid-stream -> out_valid=0 on the next cycle.
